// File: rtl/execute_muldiv_unit.sv
// Execute-stage HI/LO unit: iterative MULT/MULTU/DIV/DIVU, HI/LO registers, MFHI/MFLO/MTHI/MTLO.
// Optional MULDIV_FAST_MULT_EN: single-cycle native multiply instead of the shift-add loop.
module execute_muldiv_unit #(
  parameter int WIDTH_32 = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_E,
  input  logic                flush_E,
  input  logic [5:0]          funct_E,
  input  logic [WIDTH_32-1:0] src_a_E,
  input  logic [WIDTH_32-1:0] src_b_E,
  output logic                busy,
  output logic                stall_muldiv,
  output logic [WIDTH_32-1:0] hilo_rdata,
  output logic [WIDTH_32-1:0] hi,
  output logic [WIDTH_32-1:0] lo,
  output logic                done
);

  localparam int W  = WIDTH_32;
  localparam int CW = $clog2(W);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_MULF} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    a_raw_q, a_raw_d;
  logic            sgn_quo_q, sgn_quo_d;
  logic            sgn_rem_q, sgn_rem_d;
  logic            is_div_q, is_div_d;
  logic            dz_q, dz_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            done_q, done_d;

  logic            hilo_class;
  logic            accept;
  logic            signed_op;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      trial;
  logic [2*W-1:0]  prod_fix;
`ifdef MULDIV_FAST_MULT_EN
  logic [2*W-1:0]  fast_prod;
  logic [2*W-1:0]  fast_fix;
`endif

  always_comb begin
    case (funct_E)
      F_MFHI, F_MTHI, F_MFLO, F_MTLO,
      F_MULT, F_MULTU, F_DIV, F_DIVU: hilo_class = 1'b1;
      default:                        hilo_class = 1'b0;
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign accept       = valid_E && !flush_E && hilo_class && (state_q == S_IDLE);
  assign stall_muldiv = valid_E && hilo_class && busy;
  assign hilo_rdata   = (funct_E == F_MFHI) ? hi_q : lo_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign done         = done_q;

  assign signed_op = (funct_E == F_MULT) || (funct_E == F_DIV);
  assign a_mag     = (signed_op && src_a_E[W-1]) ? (~src_a_E + 1'b1) : src_a_E;
  assign b_mag     = (signed_op && src_b_E[W-1]) ? (~src_b_E + 1'b1) : src_b_E;
  // Restoring step: partial remainder with the next dividend bit shifted in, minus divisor.
  assign trial     = acc_q[2*W-1:W-1] - {1'b0, mplier_q};
  assign prod_fix  = sgn_quo_q ? (~acc_q + 1'b1) : acc_q;
`ifdef MULDIV_FAST_MULT_EN
  assign fast_prod = {{W{1'b0}}, mcand_q[W-1:0]} * {{W{1'b0}}, mplier_q};
  assign fast_fix  = sgn_quo_q ? (~fast_prod + 1'b1) : fast_prod;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    a_raw_d   = a_raw_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (funct_E)
            F_MTHI: hi_d = src_a_E;
            F_MTLO: lo_d = src_a_E;
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              is_div_d  = funct_E[1];
              mcand_d   = {{W{1'b0}}, a_mag};
              mplier_d  = b_mag;
              a_raw_d   = src_a_E;
              sgn_quo_d = signed_op && (src_a_E[W-1] ^ src_b_E[W-1]);
              sgn_rem_d = signed_op && src_a_E[W-1];
              dz_d      = (src_b_E == '0);
              cnt_d     = '0;
              // Divide seeds the {remainder, quotient} register with the dividend.
              acc_d     = funct_E[1] ? {{W{1'b0}}, a_mag} : '0;
`ifdef MULDIV_FAST_MULT_EN
              state_d   = funct_E[1] ? S_DIV : S_MULF;
`else
              state_d   = funct_E[1] ? S_DIV : S_MUL;
`endif
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(W-1)) state_d = S_FIX;
      end
      S_DIV: begin
        if (!trial[W]) acc_d = {trial[W-1:0], acc_q[W-2:0], 1'b1};
        else           acc_d = {acc_q[2*W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          if (dz_q) begin
            lo_d = '1;
            hi_d = a_raw_q;
          end else begin
            lo_d = sgn_quo_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
            hi_d = sgn_rem_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        cnt_d   = '0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
`ifdef MULDIV_FAST_MULT_EN
      S_MULF: begin
        {hi_d, lo_d} = fast_fix;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      a_raw_q   <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      a_raw_q   <= a_raw_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      is_div_q  <= is_div_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Bench for execute_muldiv_unit: directed corner cases plus random ops against an arithmetic model.
module tb_execute_muldiv_unit;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_E, flush_E;
  logic [5:0]  funct_E;
  logic [31:0] src_a_E, src_b_E;
  logic        busy, stall_muldiv, done;
  logic [31:0] hilo_rdata, hi, lo;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_hi, exp_lo;
  logic [63:0] exp_q[$];

  execute_muldiv_unit #(.WIDTH_32(32)) dut (
    .clk(clk), .rst(rst), .valid_E(valid_E), .flush_E(flush_E), .funct_E(funct_E),
    .src_a_E(src_a_E), .src_b_E(src_b_E), .busy(busy), .stall_muldiv(stall_muldiv),
    .hilo_rdata(hilo_rdata), .hi(hi), .lo(lo), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          ps;
    longint unsigned pu;
    int              sa, sb, sq, sr;
    int unsigned     ua, ub;
    ref_op = '0;
    sa = a; sb = b; ua = a; ub = b;
    case (f)
      F_MULT: begin
        ps = longint'(sa) * longint'(sb);
        ref_op = ps;
      end
      F_MULTU: begin
        pu = longint'(ua) * longint'(ub);
        ref_op = pu;
      end
      F_DIV, F_DIVU: begin
        if (b == 32'd0)
          ref_op = {a, 32'hFFFF_FFFF};
        else if (f == F_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          ref_op = {32'd0, 32'h8000_0000};
        else if (f == F_DIV) begin
          sq = sa / sb; sr = sa % sb;
          ref_op = {sr, sq};
        end else
          ref_op = {ua % ub, ua / ub};
      end
      default: ref_op = '0;
    endcase
  endfunction

  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic fl);
    int          cnt;
    int          lat;
    logic [63:0] e;
    @(negedge clk);
    valid_E = 1'b1; flush_E = fl; funct_E = f; src_a_E = a; src_b_E = b;
    #1;
    check("stall_idle", {63'd0, stall_muldiv}, 64'd0);
    if (f == F_MFHI) check("mfhi", {32'd0, hilo_rdata}, {32'd0, exp_hi});
    if (f == F_MFLO) check("mflo", {32'd0, hilo_rdata}, {32'd0, exp_lo});
    @(posedge clk); #1;
    valid_E = 1'b0; flush_E = 1'b0; funct_E = F_ADD;
    if (!fl && f == F_MTHI) exp_hi = a;
    if (!fl && f == F_MTLO) exp_lo = a;
    if (fl || f == F_MTHI || f == F_MTLO || f == F_MFHI || f == F_MFLO) begin
      @(negedge clk);
      check("busy_none", {63'd0, busy}, 64'd0);
      check("hi_noarith", {32'd0, hi}, {32'd0, exp_hi});
      check("lo_noarith", {32'd0, lo}, {32'd0, exp_lo});
      return;
    end
    exp_q.push_back(ref_op(f, a, b));
    lat = f[1] ? DIV_LAT : MUL_LAT;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (done) check("done_early", {63'd0, done}, 64'd0);
    end
    e = exp_q.pop_front();
    exp_hi = e[63:32]; exp_lo = e[31:0];
    check("busy_cycles", 64'(cnt), 64'(lat));
    check("done_pulse", {63'd0, done}, 64'd1);
    check("hi_result", {32'd0, hi}, {32'd0, exp_hi});
    check("lo_result", {32'd0, lo}, {32'd0, exp_lo});
    @(negedge clk);
    check("done_once", {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic [5:0]  codes [8];
    logic [5:0]  f;
    logic [31:0] a, b;
    int          cnt;
    logic [63:0] e;
    codes = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_MFHI, F_MFLO};
    rst = 1'b1; valid_E = 1'b0; flush_E = 1'b0; funct_E = F_ADD; src_a_E = '0; src_b_E = '0;
    exp_hi = '0; exp_lo = '0;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op(F_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_m3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(F_DIVU, 32'd100, 32'd7, 1'b0);
    check("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    do_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf", {hi, lo}, {32'd0, 32'h8000_0000});
    do_op(F_DIVU, 32'd5, 32'd0, 1'b0);
    check("divu_by0", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    do_op(F_DIV, 32'hFFFF_FFF0, 32'd0, 1'b0);

    do_op(F_MTHI, 32'h0000_DEAD, 32'd0, 1'b1);
    do_op(F_MTHI, 32'h0000_DEAD, 32'd0, 1'b0);
    check("mthi_dead", {32'd0, hi}, 64'h0000_DEAD);
    do_op(F_DIV, 32'd9, 32'd4, 1'b1);

    // MULTU followed by an MFLO held in E until the stall releases.
    @(negedge clk);
    valid_E = 1'b1; funct_E = F_MULTU; src_a_E = 32'h1234_5678; src_b_E = 32'h9ABC_DEF0;
    e = ref_op(F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge clk); #1;
    funct_E = F_MFLO;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall_muldiv) break;
      cnt++;
    end
    check("stall_cycles", 64'(cnt), 64'(MUL_LAT));
    check("mflo_after_stall", {32'd0, hilo_rdata}, {32'd0, e[31:0]});
    exp_hi = e[63:32]; exp_lo = e[31:0];
    @(posedge clk); #1;
    valid_E = 1'b0; funct_E = F_ADD;

    // Reset in the middle of a divide.
    @(negedge clk);
    valid_E = 1'b1; funct_E = F_DIV; src_a_E = 32'd1000; src_b_E = 32'd3;
    @(posedge clk); #1;
    repeat (10) @(negedge clk);
    check("stall_mid_div", {63'd0, stall_muldiv}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_stall", {63'd0, stall_muldiv}, 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    rst = 1'b0; valid_E = 1'b0; funct_E = F_ADD;
    do_op(F_MULT, 32'd2, 32'd3, 1'b0);
    check("mult_2x3", {hi, lo}, 64'd6);

    for (int n = 0; n < 24; n++) begin
      f = codes[$urandom_range(0, 7)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        2: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_op(f, a, b, ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
